// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALUOP classes
// (also consumed by the ALU control unit) and the controller state codes.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] ALUOP_ADD   = 3'b100;
  localparam logic [2:0] ALUOP_SUB   = 3'b111;
  localparam logic [2:0] ALUOP_ANDI  = 3'b101;
  localparam logic [2:0] ALUOP_ORI   = 3'b110;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IMMEXEC = 4'd10,
    S_IMMWB   = 4'd11
  } state_t;

  function automatic logic opcode_defined(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI: ok = 1'b1;
      default:                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    logic [2:0] aop;
    case (op)
      OP_ANDI: aop = ALUOP_ANDI;
      OP_ORI:  aop = ALUOP_ORI;
      default: aop = ALUOP_ADD;
    endcase
    return aop;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore-style multicycle MIPS controller: state register, next-state logic and
// output decode; only FETCH's PC/IR write strobes follow MemReady directly.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit ILLEGAL_PULSE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOP,
  output logic [3:0] State,
  output logic       Illegal
);

  state_t     state_r;
  state_t     next_state_s;
  logic [5:0] op_r;

  assign State = state_r;

  // State register and opcode latch; the opcode is frozen as DECODE is left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
      op_r    <= 6'b000000;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_DECODE) begin
        op_r <= Opcode;
      end else begin
        op_r <= op_r;
      end
    end
  end

  // Next-state sequencing.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:   next_state_s = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:             next_state_s = S_MEMADDR;
          OP_RTYPE:                 next_state_s = S_EXEC;
          OP_BEQ:                   next_state_s = S_BRANCH;
          OP_J:                     next_state_s = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: next_state_s = S_IMMEXEC;
          default:                  next_state_s = S_FETCH;
        endcase
      end
      S_MEMADDR: begin
        if (op_r == OP_LW) begin
          next_state_s = S_MEMRD;
        end else if (op_r == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMRD:   next_state_s = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   next_state_s = S_FETCH;
      S_MEMWR:   next_state_s = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:    next_state_s = S_RWB;
      S_RWB:     next_state_s = S_FETCH;
      S_BRANCH:  next_state_s = S_FETCH;
      S_JUMP:    next_state_s = S_FETCH;
      S_IMMEXEC: next_state_s = S_IMMWB;
      S_IMMWB:   next_state_s = S_FETCH;
      default:   next_state_s = S_FETCH;
    endcase
  end

  // Output decode from the current state; unlisted outputs stay 0.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOP       = 3'b000;
    Illegal     = 1'b0;
    case (state_r)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOP   = ALUOP_ADD;
        // Reset forces FETCH but must not let a ready memory strobe writes.
        IRWrite = MemReady & ~reset;
        PCWrite = MemReady & ~reset;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOP   = ALUOP_ADD;
        if (ILLEGAL_PULSE && !opcode_defined(Opcode)) begin
          Illegal = 1'b1;
        end else begin
          Illegal = 1'b0;
        end
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOP   = ALUOP_ADD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOP   = ALUOP_FUNCT;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOP       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IMMEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOP   = imm_aluop(op_r);
      end
      S_IMMWB: begin
        RegWrite = 1'b1;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table, hand sequences and randomized run against a queue-based model.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, Illegal;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUOP;
  logic [3:0] State;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOP(ALUOP), .State(State), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rdst;
    logic [1:0] psrc, asb;
    logic [2:0] aop;
    logic [3:0] st;
    logic ill;
  } outs_t;

  outs_t act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
                ALUOP, State, Illegal};

  typedef struct {
    logic [5:0] op;
    int         lat;
    state_t     st [6];
    logic [2:0] aop3;
    logic       ill;
    int         wb;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  task automatic add_vec(input logic [5:0] op, input int lat,
                         input state_t s2, input state_t s3, input state_t s4,
                         input logic [2:0] aop3, input logic ill, input int wb);
    vec_t v;
    v.op = op; v.lat = lat; v.aop3 = aop3; v.ill = ill; v.wb = wb;
    v.st[0] = S_FETCH; v.st[1] = S_DECODE; v.st[2] = s2;
    v.st[3] = s3; v.st[4] = s4; v.st[5] = S_FETCH;
    v.st[lat] = S_FETCH;
    vecs.push_back(v);
  endtask

  // Expected outputs for a state, written straight from the per-state rules.
  function automatic outs_t exp_outs(input state_t s, input logic mr, input logic [5:0] op,
                                     input logic [5:0] lop, input logic rst);
    outs_t o = '0;
    case (s)
      S_FETCH:   begin o.mrd = 1'b1; o.asb = 2'b01; o.aop = 3'b100;
                       o.irw = mr & !rst; o.pcw = mr & !rst; end
      S_DECODE:  begin o.asb = 2'b11; o.aop = 3'b100;
                       o.ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                            6'b000010, 6'b001000, 6'b001100, 6'b001101}); end
      S_MEMADDR: begin o.asa = 1'b1; o.asb = 2'b10; o.aop = 3'b100; end
      S_MEMRD:   begin o.mrd = 1'b1; o.iord = 1'b1; end
      S_MEMWB:   begin o.m2r = 1'b1; o.rw = 1'b1; end
      S_MEMWR:   begin o.mwr = 1'b1; o.iord = 1'b1; end
      S_EXEC:    begin o.asa = 1'b1; o.aop = 3'b010; end
      S_RWB:     begin o.rdst = 1'b1; o.rw = 1'b1; end
      S_BRANCH:  begin o.asa = 1'b1; o.aop = 3'b111; o.pcwc = 1'b1; o.psrc = 2'b01; end
      S_JUMP:    begin o.pcw = 1'b1; o.psrc = 2'b10; end
      S_IMMEXEC: begin o.asa = 1'b1; o.asb = 2'b10;
                       o.aop = (lop == 6'b001100) ? 3'b101 :
                               (lop == 6'b001101) ? 3'b110 : 3'b100; end
      S_IMMWB:   begin o.rw = 1'b1; end
      default:   o = '0;
    endcase
    o.st = 4'(s);
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  logic [5:0] legal_ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                6'b000010, 6'b001000, 6'b001100, 6'b001101};

  initial begin
    state_t     cur;
    state_t     plan[$];
    logic [5:0] lop;
    outs_t      e;

    reset = 1'b1; MemReady = 1'b1; Opcode = 6'b000000;
    #2;
    chk("reset_state", 32'(State), 32'(S_FETCH));
    chk("reset_outs", 32'(act), 32'(exp_outs(S_FETCH, 1'b1, 6'b000000, 6'b000000, 1'b1)));
    tick();
    reset = 1'b0;

    // Directed table: sequence, latency, ALUOP in cycle 3, Illegal, write-back cycle.
    add_vec(6'b100011, 5, S_MEMADDR, S_MEMRD,   S_MEMWB, 3'b100, 1'b0, 5);
    add_vec(6'b101011, 4, S_MEMADDR, S_MEMWR,   S_FETCH, 3'b100, 1'b0, 0);
    add_vec(6'b000000, 4, S_EXEC,    S_RWB,     S_FETCH, 3'b010, 1'b0, 4);
    add_vec(6'b001000, 4, S_IMMEXEC, S_IMMWB,   S_FETCH, 3'b100, 1'b0, 4);
    add_vec(6'b001100, 4, S_IMMEXEC, S_IMMWB,   S_FETCH, 3'b101, 1'b0, 4);
    add_vec(6'b001101, 4, S_IMMEXEC, S_IMMWB,   S_FETCH, 3'b110, 1'b0, 4);
    add_vec(6'b000100, 3, S_BRANCH,  S_FETCH,   S_FETCH, 3'b111, 1'b0, 0);
    add_vec(6'b000010, 3, S_JUMP,    S_FETCH,   S_FETCH, 3'b000, 1'b0, 0);
    add_vec(6'b111111, 2, S_FETCH,   S_FETCH,   S_FETCH, 3'b100, 1'b1, 0);
    add_vec(6'b010101, 2, S_FETCH,   S_FETCH,   S_FETCH, 3'b100, 1'b1, 0);

    foreach (vecs[k]) begin
      pulse_reset();
      MemReady = 1'b1;
      Opcode   = vecs[k].op;
      for (int c = 1; c <= vecs[k].lat + 1; c++) begin
        if (c == 3) Opcode = ~vecs[k].op;
        #1;
        chk($sformatf("tbl%0d_state_c%0d", k, c), 32'(State), 32'(vecs[k].st[c-1]));
        chk($sformatf("tbl%0d_ill_c%0d", k, c), 32'(Illegal), 32'((c == 2) && vecs[k].ill));
        chk($sformatf("tbl%0d_rw_c%0d", k, c), 32'(RegWrite), 32'(c == vecs[k].wb));
        if (c == 2)
          chk($sformatf("tbl%0d_we_decode", k),
              32'({PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite}), 32'd0);
        if (c == 3 && vecs[k].lat >= 3)
          chk($sformatf("tbl%0d_aluop_c3", k), 32'(ALUOP), 32'(vecs[k].aop3));
        tick();
      end
    end

    // FETCH stalls while memory is not ready.
    pulse_reset();
    Opcode = 6'b000000; MemReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_wr", 32'({IRWrite, PCWrite}), 32'd0);
      chk("stall_state", 32'(State), 32'(S_FETCH));
      tick();
    end
    MemReady = 1'b1;
    #1;
    chk("stall_release_wr", 32'({IRWrite, PCWrite}), 32'b11);
    tick();
    chk("stall_decode", 32'(State), 32'(S_DECODE));

    // Asynchronous reset during a stalled store.
    pulse_reset();
    Opcode = 6'b101011; MemReady = 1'b1;
    tick(); tick(); tick();
    MemReady = 1'b0;
    #1;
    chk("sw_in_memwr", 32'({State, MemWrite}), 32'({4'(S_MEMWR), 1'b1}));
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(State), 32'(S_FETCH));
    chk("async_rst_mwr", 32'(MemWrite), 32'd0);
    chk("async_rst_pcw", 32'({PCWrite, IRWrite}), 32'd0);
    tick();
    reset = 1'b0; MemReady = 1'b1;
    tick();
    chk("post_rst_decode", 32'(State), 32'(S_DECODE));

    // Randomized run against a queue-based instruction model.
    pulse_reset();
    cur = S_FETCH; lop = 6'b000000; plan.delete();
    for (int n = 0; n < 3000; n++) begin
      MemReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 8) Opcode = legal_ops[$urandom_range(0, 7)];
      else Opcode = 6'($urandom);
      #1;
      e = exp_outs(cur, MemReady, Opcode, lop, 1'b0);
      chk("rand_outs", 32'(act), 32'(e));
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        #1;
        cur = S_FETCH; lop = 6'b000000; plan.delete();
        chk("rand_rst_outs", 32'(act), 32'(exp_outs(S_FETCH, MemReady, Opcode, lop, 1'b1)));
        tick();
        reset = 1'b0;
      end else begin
        case (cur)
          S_FETCH: if (MemReady) cur = S_DECODE;
          S_DECODE: begin
            lop = Opcode;
            case (Opcode)
              6'b100011: plan = '{S_MEMADDR, S_MEMRD, S_MEMWB};
              6'b101011: plan = '{S_MEMADDR, S_MEMWR};
              6'b000000: plan = '{S_EXEC, S_RWB};
              6'b000100: plan = '{S_BRANCH};
              6'b000010: plan = '{S_JUMP};
              6'b001000, 6'b001100, 6'b001101: plan = '{S_IMMEXEC, S_IMMWB};
              default:   plan.delete();
            endcase
            cur = (plan.size() > 0) ? plan.pop_front() : S_FETCH;
          end
          S_MEMRD, S_MEMWR:
            if (MemReady) cur = (plan.size() > 0) ? plan.pop_front() : S_FETCH;
          default: cur = (plan.size() > 0) ? plan.pop_front() : S_FETCH;
        endcase
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
